// File: rtl/pulpemu_trace_buf.sv
// -----------------------------------------------------------------------------
// pulpemu_trace_buf
//
// On-FPGA instruction-trace capture buffer. Each cycle the per-core retired
// instruction records (cycle count, instruction, PC, valid) are registered
// (R stage). One cycle later, if any core was valid, the whole record set is
// packed into one buffer entry of NB_CORES*4 32-bit words and written at the
// write pointer.
//
// Capture modes (latched on the fetch_en_i rising edge):
//   stop mode - once TRACE_THRESHOLD entries are stored the cores are stalled
//               via trace_wait_o until the host pulses flush_i. Entries still
//               in flight are stored until the buffer is full, then counted
//               as dropped.
//   wrap mode - ring buffer, the oldest entry is overwritten, never stalls.
//               Only present when the macro PULPEMU_TRACE_WRAP_EN is defined;
//               otherwise wrap_mode_i is ignored and wrapped_o is tied to 0.
//
// Entry layout for core c (words 4c..4c+3):
//   w0 = cycles[31:0], w1 = {valid[c], 3'b0, cycles[59:32]}, w2 = instr, w3 = pc
//
// Ports:
//   ref_clk_i, rst_i        clock, synchronous active-high reset
//   fetch_en_i              capture enable, rising edge starts a capture
//   wrap_mode_i             1 = wrap mode, sampled on fetch_en_i rising edge
//   trace_cycles_i/instr_i/pc_i/valid_i   per-core trace records
//   flush_i                 host drained the buffer: clear count/pointer/wait
//   trace_wait_o            stall request to the cores (registered)
//   rd_addr_i, rd_data_o    host read port {entry, word}, one cycle latency
//   entry_count_o           number of valid entries
//   wr_ptr_o                next entry to be written (oldest entry after wrap)
//   wrapped_o               wrap mode has overwritten an entry
//   drop_cnt_o              saturating count of discarded entries
// -----------------------------------------------------------------------------
module pulpemu_trace_buf #(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned TRACE_DEPTH     = 1024,
    parameter int unsigned TRACE_THRESHOLD = 1000
) (
    input  logic                                                   ref_clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   fetch_en_i,
    input  logic                                                   wrap_mode_i,
    input  logic [NB_CORES*64-1:0]                                 trace_cycles_i,
    input  logic [NB_CORES*32-1:0]                                 trace_instr_i,
    input  logic [NB_CORES*32-1:0]                                 trace_pc_i,
    input  logic [NB_CORES-1:0]                                    trace_valid_i,
    input  logic                                                   flush_i,
    output logic                                                   trace_wait_o,
    input  logic [$clog2(TRACE_DEPTH)+$clog2(NB_CORES*4)-1:0]      rd_addr_i,
    output logic [31:0]                                            rd_data_o,
    output logic [$clog2(TRACE_DEPTH):0]                           entry_count_o,
    output logic [$clog2(TRACE_DEPTH)-1:0]                         wr_ptr_o,
    output logic                                                   wrapped_o,
    output logic [15:0]                                            drop_cnt_o
);

    localparam int unsigned WPE = NB_CORES * 4;          // words per entry
    localparam int unsigned WW  = $clog2(WPE);           // word index width
    localparam int unsigned PW  = $clog2(TRACE_DEPTH);   // pointer width
    localparam int unsigned CW  = PW + 1;                // count width
    localparam int unsigned AW  = PW + WW;               // read address width

    localparam logic [CW-1:0] DEPTH_C  = CW'(TRACE_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(TRACE_THRESHOLD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2
    } state_e;

    // R stage
    logic                     fetch_en_q;
    logic [NB_CORES-1:0]      valid_q;
    logic [NB_CORES*60-1:0]   cycles_q;
    logic [NB_CORES*32-1:0]   instr_q;
    logic [NB_CORES*32-1:0]   pc_q;

    // Control
    state_e                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic                     wrapped_q, wrapped_d;
    logic [15:0]              drop_q, drop_d;
    logic                     wait_q, wait_d;
`ifdef PULPEMU_TRACE_WRAP_EN
    logic                     mode_q, mode_d;            // 1 = wrap mode
`else
    logic                     unused_wrap_mode_s;
`endif

    logic                     rise_s;
    logic                     entry_s;
    logic                     we_s;
    logic [31:0]              entry_word_s [WPE];
    logic [NB_CORES*4-1:0]    unused_cycles_hi_s;

    // Buffer and read port
    logic [31:0]              mem_q [TRACE_DEPTH][WPE];
    logic [31:0]              rd_data_q;
    logic [PW-1:0]            rd_entry_s;
    logic [WW-1:0]            rd_word_s;

    // Second entry word: valid flag above the upper 28 bits of the cycle count.
    function automatic logic [31:0] pack_hi_word(input logic valid, input logic [27:0] cyc_hi);
        pack_hi_word = {valid, 3'b000, cyc_hi};
    endfunction

    assign rise_s     = fetch_en_i & ~fetch_en_q;
    assign entry_s    = |valid_q;
    assign rd_entry_s = rd_addr_i[AW-1:WW];
    assign rd_word_s  = rd_addr_i[WW-1:0];

`ifndef PULPEMU_TRACE_WRAP_EN
    assign unused_wrap_mode_s = wrap_mode_i;
`endif

    // R stage: register all trace inputs every cycle (cycle bits 63:60 are not kept).
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            fetch_en_q <= 1'b0;
            valid_q    <= '0;
            cycles_q   <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            fetch_en_q <= fetch_en_i;
            valid_q    <= trace_valid_i;
            instr_q    <= trace_instr_i;
            pc_q       <= trace_pc_i;
            for (int c = 0; c < NB_CORES; c++) begin
                cycles_q[60*c +: 60] <= trace_cycles_i[64*c +: 60];
            end
        end
    end

    // Pack the registered records into one entry; collect the discarded cycle bits.
    always_comb begin
        unused_cycles_hi_s = '0;
        for (int w = 0; w < WPE; w++) begin
            entry_word_s[w] = 32'h0000_0000;
        end
        for (int c = 0; c < NB_CORES; c++) begin
            entry_word_s[4*c+0]           = cycles_q[60*c +: 32];
            entry_word_s[4*c+1]           = pack_hi_word(valid_q[c], cycles_q[60*c+32 +: 28]);
            entry_word_s[4*c+2]           = instr_q[32*c +: 32];
            entry_word_s[4*c+3]           = pc_q[32*c +: 32];
            unused_cycles_hi_s[4*c +: 4]  = trace_cycles_i[64*c+60 +: 4];
        end
    end

    // Capture FSM next state, counters and buffer write enable.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        drop_d    = drop_q;
        we_s      = 1'b0;
`ifdef PULPEMU_TRACE_WRAP_EN
        mode_d    = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d   = ST_CAPTURE;
                    count_d   = '0;
                    wr_ptr_d  = '0;
                    wrapped_d = 1'b0;
                    drop_d    = 16'h0000;
`ifdef PULPEMU_TRACE_WRAP_EN
                    mode_d    = wrap_mode_i;
`endif
                end else if (flush_i) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE, ST_WAIT: begin
                if (!fetch_en_i) begin
                    // Capture stops; an entry arriving now is discarded.
                    state_d = ST_IDLE;
                    if (flush_i) begin
                        count_d  = '0;
                        wr_ptr_d = '0;
                    end else begin
                        count_d = count_q;
                    end
                end else if (flush_i) begin
                    // Flush beats a coincident entry, which is not counted as dropped.
                    state_d  = ST_CAPTURE;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (entry_s) begin
`ifdef PULPEMU_TRACE_WRAP_EN
                    if (mode_q) begin
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (count_q == DEPTH_C) begin
                            wrapped_d = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end else
`endif
                    if (count_q < DEPTH_C) begin
                        // Stop mode: in-flight entries keep landing until the buffer is full.
                        we_s     = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        count_d  = count_q + CW'(1);
                        if (count_q + CW'(1) == THRESH_C) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'h0001;
                        end else begin
                            drop_d = drop_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wait_d = (state_d == ST_WAIT);
    end

    // Control state registers.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
            drop_q    <= 16'h0000;
            wait_q    <= 1'b0;
`ifdef PULPEMU_TRACE_WRAP_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            wrapped_q <= wrapped_d;
            drop_q    <= drop_d;
            wait_q    <= wait_d;
`ifdef PULPEMU_TRACE_WRAP_EN
            mode_q    <= mode_d;
`endif
        end
    end

    // Buffer write: contents are intentionally not cleared by reset.
    always_ff @(posedge ref_clk_i) begin
        if (we_s && !rst_i) begin
            for (int w = 0; w < WPE; w++) begin
                mem_q[wr_ptr_q][w] <= entry_word_s[w];
            end
        end
    end

    // Registered read port; a same-edge write is not visible (old data returned).
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            rd_data_q <= 32'h0000_0000;
        end else begin
            rd_data_q <= mem_q[rd_entry_s][rd_word_s];
        end
    end

    assign trace_wait_o  = wait_q;
    assign rd_data_o     = rd_data_q;
    assign entry_count_o = count_q;
    assign wr_ptr_o      = wr_ptr_q;
    assign drop_cnt_o    = drop_q;
`ifdef PULPEMU_TRACE_WRAP_EN
    assign wrapped_o     = wrapped_q;
`else
    assign wrapped_o     = 1'b0;
`endif

endmodule

// File: tb/tb_pulpemu_trace_buf.sv
module tb_pulpemu_trace_buf;

    localparam int NC  = 4;
    localparam int D   = 16;
    localparam int T   = 12;
    localparam int WPE = NC * 4;
    localparam int AW  = 8;

`ifdef PULPEMU_TRACE_WRAP_EN
    localparam bit WRAP_AVAIL = 1'b1;
`else
    localparam bit WRAP_AVAIL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic              wrap_mode;
    logic [NC*64-1:0]  cyc;
    logic [NC*32-1:0]  instr;
    logic [NC*32-1:0]  pc;
    logic [NC-1:0]     valid;
    logic              flush;
    logic              trace_wait;
    logic [AW-1:0]     rd_addr;
    logic [31:0]       rd_data;
    logic [4:0]        entry_count;
    logic [3:0]        wr_ptr;
    logic              wrapped;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulpemu_trace_buf #(
        .NB_CORES       (NC),
        .TRACE_DEPTH    (D),
        .TRACE_THRESHOLD(T)
    ) dut (
        .ref_clk_i     (clk),
        .rst_i         (rst),
        .fetch_en_i    (fetch_en),
        .wrap_mode_i   (wrap_mode),
        .trace_cycles_i(cyc),
        .trace_instr_i (instr),
        .trace_pc_i    (pc),
        .trace_valid_i (valid),
        .flush_i       (flush),
        .trace_wait_o  (trace_wait),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .entry_count_o (entry_count),
        .wr_ptr_o      (wr_ptr),
        .wrapped_o     (wrapped),
        .drop_cnt_o    (drop_cnt)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0]      m_buf [D][WPE];
    bit               m_written [D];
    int               m_count, m_wp, m_drop;
    bit               m_wrapped, m_wait, m_run, m_mode, m_prev_fetch;
    logic [31:0]      m_rd;
    bit               m_rd_known;
    logic [NC-1:0]    r_valid;
    logic [NC*64-1:0] r_cyc;
    logic [NC*32-1:0] r_instr, r_pc;

    task automatic m_clear_all();
        m_count = 0; m_wp = 0; m_drop = 0; m_wrapped = 0;
    endtask

    task automatic m_store();
        for (int c = 0; c < NC; c++) begin
            m_buf[m_wp][4*c+0] = r_cyc[64*c +: 32];
            m_buf[m_wp][4*c+1] = {r_valid[c], 3'b000, r_cyc[64*c+32 +: 28]};
            m_buf[m_wp][4*c+2] = r_instr[32*c +: 32];
            m_buf[m_wp][4*c+3] = r_pc[32*c +: 32];
        end
        m_written[m_wp] = 1'b1;
        m_wp = (m_wp + 1) % D;
    endtask

    // One clock edge of the reference behaviour, from the currently driven inputs.
    task automatic model_edge();
        int e;
        if (rst) begin
            m_clear_all();
            m_wait = 0; m_run = 0; m_mode = 0; m_prev_fetch = 0;
            r_valid = '0; r_cyc = '0; r_instr = '0; r_pc = '0;
            m_rd = 32'h0; m_rd_known = 1'b1;
            return;
        end
        e = int'(rd_addr) / WPE;
        m_rd_known = m_written[e];
        m_rd = m_buf[e][int'(rd_addr) % WPE];
        if (!m_run) begin
            if (fetch_en && !m_prev_fetch) begin
                m_clear_all();
                m_run = 1; m_wait = 0;
                m_mode = WRAP_AVAIL && wrap_mode;
            end else if (flush) begin
                m_count = 0; m_wp = 0;
            end
        end else if (!fetch_en) begin
            m_run = 0; m_wait = 0;
            if (flush) begin m_count = 0; m_wp = 0; end
        end else if (flush) begin
            m_count = 0; m_wp = 0; m_wait = 0;
        end else if (r_valid != '0) begin
            if (m_mode) begin
                m_store();
                if (m_count == D) m_wrapped = 1; else m_count++;
            end else if (m_count < D) begin
                m_store();
                m_count++;
                if (m_count >= T) m_wait = 1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        r_valid = valid; r_cyc = cyc; r_instr = instr; r_pc = pc;
        m_prev_fetch = fetch_en;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("wait",    64'(trace_wait),  64'(m_wait));
        chk("count",   64'(entry_count), 64'(m_count));
        chk("wr_ptr",  64'(wr_ptr),      64'(m_wp));
        chk("wrapped", 64'(wrapped),     64'(m_wrapped));
        chk("drop",    64'(drop_cnt),    64'(m_drop));
        if (m_rd_known) chk("rd_data", 64'(rd_data), 64'(m_rd));
    endtask

    // Inputs are changed only at the falling edge; outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       fetch;
        bit       flush;
        bit [3:0] valid;
        int       exp_count;
        bit       exp_wait;
        int       exp_drop;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(bit f, bit fl, bit [3:0] v, int c, bit w, int d);
        vec_t x;
        x.fetch = f; x.flush = fl; x.valid = v;
        x.exp_count = c; x.exp_wait = w; x.exp_drop = d;
        return x;
    endfunction

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; valid = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bit saw_wait;
        for (int e = 0; e < D; e++) m_written[e] = 1'b0;
        rst = 1'b1; fetch_en = 1'b0; wrap_mode = 1'b0; flush = 1'b0;
        valid = '0; cyc = '0; instr = '0; pc = '0; rd_addr = '0;

        // Row expectations: outputs seen after that row's clock edge.
        tbl[0] = mk(1, 0, 4'h0, 0, 0, 0);
        for (int r = 1; r <= 12; r++) tbl[r] = mk(1, 0, 4'hF, r - 1, 0, 0);
        tbl[13] = mk(1, 0, 4'hF, 12, 1, 0);
        tbl[14] = mk(1, 0, 4'hF, 13, 1, 0);
        tbl[15] = mk(1, 0, 4'hF, 14, 1, 0);
        tbl[16] = mk(1, 0, 4'hF, 15, 1, 0);
        tbl[17] = mk(1, 0, 4'hF, 16, 1, 0);
        tbl[18] = mk(1, 0, 4'hF, 16, 1, 1);
        tbl[19] = mk(1, 0, 4'h0, 16, 1, 2);
        tbl[20] = mk(1, 1, 4'h0, 0, 0, 2);
        tbl[21] = mk(1, 0, 4'h1, 0, 0, 2);
        tbl[22] = mk(1, 1, 4'h0, 0, 0, 2);
        tbl[23] = mk(1, 0, 4'h0, 0, 0, 2);
        tbl[24] = mk(0, 0, 4'h0, 0, 0, 2);

        // Reset state
        tick();
        chk("rst_wait",    64'(trace_wait),  64'd0);
        chk("rst_count",   64'(entry_count), 64'd0);
        chk("rst_wr_ptr",  64'(wr_ptr),      64'd0);
        chk("rst_wrapped", 64'(wrapped),     64'd0);
        chk("rst_drop",    64'(drop_cnt),    64'd0);
        chk("rst_rd_data", 64'(rd_data),     64'd0);
        rst = 1'b0;
        tick();

        // Stop mode: threshold, drops during WAIT, flush, flush-with-entry
        for (int i = 0; i < 25; i++) begin
            fetch_en = tbl[i].fetch;
            flush    = tbl[i].flush;
            valid    = tbl[i].valid;
            pc       = {4{32'(i)}};
            cyc      = rnd256();
            instr    = rnd256()[127:0];
            rd_addr  = AW'($urandom);
            tick();
            chk("tbl_count", 64'(entry_count), 64'(tbl[i].exp_count));
            chk("tbl_wait",  64'(trace_wait),  64'(tbl[i].exp_wait));
            chk("tbl_drop",  64'(drop_cnt),    64'(tbl[i].exp_drop));
        end
        flush = 1'b0;

        // Entry packing: core 2 only
        do_reset();
        fetch_en = 1'b1; tick();
        cyc   = {64'h1111_2222_3333_4444, 64'h0ABC_DEF0_1234_5678,
                 64'h5555_6666_7777_8888, 64'hFFFF_FFFF_FFFF_FFFF};
        instr = {32'hAAAA_AAAA, 32'h0000_0013, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        pc    = {32'hDDDD_DDDD, 32'h1C00_8080, 32'hEEEE_EEEE, 32'h9999_9999};
        valid = 4'b0100;
        tick();
        valid = 4'b0000;
        tick();
        rd_addr = 8'd8;  tick(); chk("w8",  64'(rd_data), 64'h1234_5678);
        rd_addr = 8'd9;  tick(); chk("w9",  64'(rd_data), 64'h8ABC_DEF0);
        rd_addr = 8'd10; tick(); chk("w10", 64'(rd_data), 64'h0000_0013);
        rd_addr = 8'd11; tick(); chk("w11", 64'(rd_data), 64'h1C00_8080);
        rd_addr = 8'd1;  tick(); chk("w1_valid_bit", 64'(rd_data[31]), 64'd0);

        // Wrap mode: 20 entries with PC 0..19
        do_reset();
        fetch_en = 1'b1; wrap_mode = 1'b1; tick();
        wrap_mode = 1'b0;
        saw_wait = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid = 4'b0001; pc = {4{32'(i)}}; cyc = rnd256();
            tick();
            saw_wait |= trace_wait;
        end
        valid = 4'b0000;
        tick(); saw_wait |= trace_wait;
        rd_addr = 8'd67;
        tick(); saw_wait |= trace_wait;
        if (WRAP_AVAIL) begin
            chk("wrap_wrapped", 64'(wrapped),     64'd1);
            chk("wrap_wr_ptr",  64'(wr_ptr),      64'd4);
            chk("wrap_count",   64'(entry_count), 64'd16);
            chk("wrap_entry4",  64'(rd_data),     64'd4);
            chk("wrap_no_wait", 64'(saw_wait),    64'd0);
        end else begin
            chk("stop_wrapped", 64'(wrapped),     64'd0);
            chk("stop_wr_ptr",  64'(wr_ptr),      64'd0);
            chk("stop_count",   64'(entry_count), 64'd16);
            chk("stop_drop",    64'(drop_cnt),    64'd4);
            chk("stop_wait",    64'(trace_wait),  64'd1);
        end

        // Reset mid-capture
        rst = 1'b1; valid = 4'hF;
        tick();
        chk("midrst_wait",    64'(trace_wait),  64'd0);
        chk("midrst_count",   64'(entry_count), 64'd0);
        chk("midrst_wr_ptr",  64'(wr_ptr),      64'd0);
        chk("midrst_wrapped", 64'(wrapped),     64'd0);
        chk("midrst_drop",    64'(drop_cnt),    64'd0);
        chk("midrst_rd_data", 64'(rd_data),     64'd0);
        rst = 1'b0;

        // Randomised traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            rst       = ($urandom_range(0, 999) < 3);
            fetch_en  = ($urandom_range(0, 99) >= 5);
            flush     = ($urandom_range(0, 99) < 4);
            wrap_mode = $urandom_range(0, 1) == 1;
            valid     = ($urandom_range(0, 99) < 30) ? 4'h0 : 4'($urandom);
            cyc       = rnd256();
            instr     = rnd256()[127:0];
            pc        = rnd256()[127:0];
            rd_addr   = AW'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulpemu_trace_buf.md
# pulpemu_trace_buf

Parametrised on-FPGA instruction-trace capture buffer for the pulpemu platform.
- Registers per-core retired-instruction records (cycle count, instruction, PC) and packs them into an entry-wide on-chip buffer.
- Operates in stop-on-threshold mode (stalls cores via `trace_wait_o` until the host flushes) or wrap mode (ring buffer, oldest overwritten, no stall).
- Host reads entries through a 32-bit word port in the same clock domain.

## Interface
- `NB_CORES`, 4: traced cores; power of 2, 1..16.
- `TRACE_DEPTH`, 1024: entries; power of 2, ≥8.
- `TRACE_THRESHOLD`, 1000: stop-mode fill level that raises `trace_wait_o`; 1 ≤ value ≤ `TRACE_DEPTH`.
- `ref_clk_i` in 1: sole clock.
- `rst_i` in 1: synchronous, active-high reset.
- `fetch_en_i` in 1: capture enable; a rising edge starts a new capture.
- `wrap_mode_i` in 1: 1 = wrap mode, 0 = stop mode; sampled only on the `fetch_en_i` rising edge.
- `trace_cycles_i` in NB_CORES*64: per-core cycle counter; bits [59:0] used.
- `trace_instr_i` in NB_CORES*32: per-core instruction.
- `trace_pc_i` in NB_CORES*32: per-core PC.
- `trace_valid_i` in NB_CORES: per-core record valid.
- `flush_i` in 1: host has drained the buffer; clears count, pointers and wait.
- `trace_wait_o` out 1: stall request to cores.
- `rd_addr_i` in clog2(TRACE_DEPTH)+clog2(NB_CORES*4): address, {entry, word}.
- `rd_data_o` out 32: read data.
- `entry_count_o` out clog2(TRACE_DEPTH)+1: valid entries.
- `wr_ptr_o` out clog2(TRACE_DEPTH): next write entry.
- `wrapped_o` out 1: wrap mode has overwritten at least one entry.
- `drop_cnt_o` out 16: saturating count of discarded entries.

## Operation
- Input stage: all trace inputs are registered every cycle (R stage). An entry is generated when the registered `|valid` is 1.
- Entry layout for core c, words 4c..4c+3:
  - w0 = cycles[31:0]
  - w1 = {valid[c], 3'b0, cycles[59:32]}
  - w2 = instr
  - w3 = pc
  - Invalid cores are still stored; they carry valid bit 0.
- States:
  - IDLE: no writes.
  - CAPTURE: entries are written at `wr_ptr`, then `wr_ptr`++ and count++.
  - WAIT: stop mode only, `trace_wait_o`=1.
- Transitions:
  - IDLE→CAPTURE on `fetch_en_i` rising edge: clears count, pointers, `wrapped_o`, `drop_cnt_o`; latches mode.
  - Any→IDLE on `fetch_en_i`=0. Contents and status are held for readout.
  - CAPTURE→WAIT (stop mode) when count reaches `TRACE_THRESHOLD`.
  - WAIT→CAPTURE on `flush_i`.
  - `flush_i` in CAPTURE clears count and `wr_ptr` and stays in CAPTURE.
- WAIT writes: entries still in flight are written while count < `TRACE_DEPTH`. At count = `TRACE_DEPTH` they are discarded and `drop_cnt_o`++, saturating at 0xFFFF.
- Wrap mode:
  - `wr_ptr` wraps from `TRACE_DEPTH`-1 to 0.
  - Count saturates at `TRACE_DEPTH`.
  - `wrapped_o` sets on the first write at full count; the oldest entry is at `wr_ptr_o`.
  - `trace_wait_o` never asserts.
- Simultaneous events:
  - `flush_i` together with an entry: flush wins; the entry is discarded and not counted in `drop_cnt_o`.
  - `fetch_en_i` falling together with an entry: the entry is discarded.
  - Reset mid-capture: all state is cleared. Buffer contents are undefined and are not cleared.
- Read port: pure lookup, with no side effects on capture.

## Timing
- Trace inputs in cycle N → R stage at edge N+1 → buffer write, pointer and count update at edge N+2.
- `trace_wait_o` is registered. It is 1 in the cycle after the edge at which count becomes `TRACE_THRESHOLD`, and 0 in the cycle after the edge that samples `flush_i`.
- `rd_data_o` is valid one cycle after `rd_addr_i`. Read-during-write to the same entry returns old data.
- Reset values:
  - `trace_wait_o`=0
  - `entry_count_o`=0
  - `wr_ptr_o`=0
  - `wrapped_o`=0
  - `drop_cnt_o`=0
  - `rd_data_o`=0
  - state = IDLE
  - R stage = 0
- Sustained throughput: one entry per cycle.

## Configuration
- `PULPEMU_TRACE_WRAP_EN` defined: wrap mode is available as described.
- Without it: `wrap_mode_i` is ignored, the block is stop mode only, `wrapped_o` is tied to 0, and the wrap logic is removed.

## Test plan
- NB_CORES=4, DEPTH=16, THRESHOLD=12, stop mode, 12 consecutive valid cycles → `trace_wait_o`=1 from the cycle after the 12th write; `entry_count_o`=12.
- Same setup, 6 further entries during WAIT → 4 written (count 16) and `drop_cnt_o`=2. Then `flush_i` → count 0, `trace_wait_o`=0 one cycle later.
- Core 2 only valid, cycles=0x0ABCDEF012345678, instr=0x00000013, pc=0x1C008080 → entry 0 words 8..11 read back:
  - w8 = 0x12345678
  - w9 = 0x8ABCDEF0
  - w10 = 0x00000013
  - w11 = 0x1C008080
  - core 0 w1 bit 31 = 0
- Wrap mode, DEPTH=16, 20 entries with PC 0..19 → `wrapped_o`=1, `wr_ptr_o`=4, count 16, entry 4 holds PC 4, `trace_wait_o` stays 0.
- `flush_i` and a valid entry in the same cycle → count 0 and `drop_cnt_o` unchanged.
- `rst_i` mid-capture → all outputs at reset values on the next cycle.
